// File: rtl/display_pkg.sv
// Shared types and constants for the six-digit decimal display:
// FSM states, segment patterns and the BCD correction step.
package display_pkg;

    localparam int NUM_DIGITS = 6;
    localparam int BIN_W      = 20;
    localparam int BCD_W      = 4 * NUM_DIGITS;
    localparam int CNT_W      = 5;

    localparam logic [BIN_W-1:0] MAX_VALUE = 20'd999999;

    typedef enum logic [1:0] {
        IDLE,
        CONVERT,
        UPDATE
    } state_e;

    localparam logic [6:0] SEG_BLANK = 7'h7F;
    localparam logic [6:0] SEG_DASH  = 7'h3F;

    // Index 0 is the rightmost entry.
    localparam logic [9:0][6:0] SEG_DIGITS = {
        7'h10, 7'h00, 7'h78, 7'h02, 7'h12,
        7'h19, 7'h30, 7'h24, 7'h79, 7'h40
    };

    function automatic logic [BCD_W-1:0] bcd_adjust(
        input logic [BCD_W-1:0] b
    );
        logic [BCD_W-1:0] r;
        r = b;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (b[4*i +: 4] >= 4'd5) begin
                r[4*i +: 4] = b[4*i +: 4] + 4'd3;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/seven_seg_digit.sv
// One BCD digit to an active-low 7-segment pattern.
// Non-decimal codes show as blank.
module seven_seg_digit
    import display_pkg::*;
(
    input  logic [3:0] digit_i,
    input  logic       blank_i,
    output logic [6:0] seg_o
);

    always_comb begin
        seg_o = SEG_BLANK;
        if (!blank_i && (digit_i < 4'd10)) begin
            seg_o = SEG_DIGITS[digit_i];
        end
    end

endmodule

// File: rtl/decimal_display.sv
// 20-bit binary to six 7-segment digits via sequential shift-add-3,
// with overflow dashes and optional leading-zero blanking.
module decimal_display
    import display_pkg::*;
#(
    parameter bit BLANK_LEADING_ZEROS = 1'b1,
    parameter bit SEG_ACTIVE_LOW      = 1'b1
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             start,
    input  logic [BIN_W-1:0] bin,
    output logic             busy,
    output logic             done,
    output logic [6:0]       hex0,
    output logic [6:0]       hex1,
    output logic [6:0]       hex2,
    output logic [6:0]       hex3,
    output logic [6:0]       hex4,
    output logic [6:0]       hex5
);

    localparam logic [6:0] POL_MASK  = SEG_ACTIVE_LOW ? 7'h00 : 7'h7F;
    localparam logic [6:0] BLANK_OUT = SEG_BLANK ^ POL_MASK;

    state_e                       state_q, state_d;
    logic [BIN_W-1:0]             shift_q, shift_d;
    logic [BCD_W-1:0]             bcd_q, bcd_d;
    logic [CNT_W-1:0]             cnt_q, cnt_d;
    logic                         ovf_q, ovf_d;
    logic                         done_q, done_d;
    logic [NUM_DIGITS-1:0][6:0]   hex_q, hex_d;
    logic [NUM_DIGITS-1:0][6:0]   seg_raw;
    logic [NUM_DIGITS-1:0][6:0]   disp;
    logic [NUM_DIGITS-1:0]        blank;

    // A digit blanks while it and every digit above it are zero.
    always_comb begin
        logic run;
        blank = '0;
        run   = BLANK_LEADING_ZEROS;
        for (int i = NUM_DIGITS - 1; i > 0; i--) begin
            run      = run && (bcd_q[4*i +: 4] == 4'd0);
            blank[i] = run;
        end
    end

    for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_digit
        seven_seg_digit u_digit (
            .digit_i (bcd_q[4*g +: 4]),
            .blank_i (blank[g]),
            .seg_o   (seg_raw[g])
        );
    end

    always_comb begin
        disp = '0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            disp[i] = (ovf_q ? SEG_DASH : seg_raw[i]) ^ POL_MASK;
        end
    end

    always_comb begin
        state_d = state_q;
        shift_d = shift_q;
        bcd_d   = bcd_q;
        cnt_d   = cnt_q;
        ovf_d   = ovf_q;
        done_d  = 1'b0;
        hex_d   = hex_q;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    shift_d = bin;
                    bcd_d   = '0;
                    cnt_d   = CNT_W'(BIN_W);
                    ovf_d   = (bin > MAX_VALUE);
                    state_d = CONVERT;
                end
            end
            CONVERT: begin
                {bcd_d, shift_d} = {bcd_adjust(bcd_q), shift_q} << 1;
                cnt_d = cnt_q - 5'd1;
                if (cnt_q == 5'd1) begin
                    state_d = UPDATE;
                end
            end
            UPDATE: begin
                hex_d   = disp;
                done_d  = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            shift_q <= '0;
            bcd_q   <= '0;
            cnt_q   <= '0;
            ovf_q   <= 1'b0;
            done_q  <= 1'b0;
            hex_q   <= {NUM_DIGITS{BLANK_OUT}};
        end else begin
            state_q <= state_d;
            shift_q <= shift_d;
            bcd_q   <= bcd_d;
            cnt_q   <= cnt_d;
            ovf_q   <= ovf_d;
            done_q  <= done_d;
            hex_q   <= hex_d;
        end
    end

    assign busy = (state_q != IDLE);
    assign done = done_q;
    assign hex0 = hex_q[0];
    assign hex1 = hex_q[1];
    assign hex2 = hex_q[2];
    assign hex3 = hex_q[3];
    assign hex4 = hex_q[4];
    assign hex5 = hex_q[5];

endmodule

// File: tb/tb_decimal_display.sv
// Scoreboard bench for decimal_display: default, no-blanking
// and active-high instances driven from the same stimulus.
module tb_decimal_display;

    logic        clock = 1'b0;
    logic        reset_n;
    logic        start;
    logic [19:0] bin;

    logic        busy_a, done_a, busy_b, done_b, busy_c, done_c;
    logic [6:0]  ha [6];
    logic [6:0]  hb [6];
    logic [6:0]  hc [6];
    logic [41:0] hex_a, hex_b, hex_c;

    assign hex_a = {ha[5], ha[4], ha[3], ha[2], ha[1], ha[0]};
    assign hex_b = {hb[5], hb[4], hb[3], hb[2], hb[1], hb[0]};
    assign hex_c = {hc[5], hc[4], hc[3], hc[2], hc[1], hc[0]};

    typedef struct packed {
        logic [19:0] v;
        logic [41:0] a;
        logic [41:0] nb;
        logic [41:0] inv;
    } exp_t;

    exp_t sb [$];
    int   n_pass = 0;
    int   n_tot  = 0;

    always #5 clock = ~clock;

    decimal_display dut_a (
        .clock(clock), .reset_n(reset_n), .start(start), .bin(bin),
        .busy(busy_a), .done(done_a),
        .hex0(ha[0]), .hex1(ha[1]), .hex2(ha[2]),
        .hex3(ha[3]), .hex4(ha[4]), .hex5(ha[5])
    );

    decimal_display #(.BLANK_LEADING_ZEROS(1'b0)) dut_b (
        .clock(clock), .reset_n(reset_n), .start(start), .bin(bin),
        .busy(busy_b), .done(done_b),
        .hex0(hb[0]), .hex1(hb[1]), .hex2(hb[2]),
        .hex3(hb[3]), .hex4(hb[4]), .hex5(hb[5])
    );

    decimal_display #(.SEG_ACTIVE_LOW(1'b0)) dut_c (
        .clock(clock), .reset_n(reset_n), .start(start), .bin(bin),
        .busy(busy_c), .done(done_c),
        .hex0(hc[0]), .hex1(hc[1]), .hex2(hc[2]),
        .hex3(hc[3]), .hex4(hc[4]), .hex5(hc[5])
    );

    function automatic logic [41:0] model(int v, bit blz, bit al);
        logic [6:0]  tbl [10];
        logic [41:0] r;
        logic [6:0]  s;
        bit          run;
        int          d, p;
        tbl = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
                7'h12, 7'h02, 7'h78, 7'h00, 7'h10};
        r   = '0;
        run = blz;
        for (int i = 5; i >= 0; i--) begin
            p = 1;
            for (int j = 0; j < i; j++) p = p * 10;
            d = (v / p) % 10;
            if (i > 0) run = run && (d == 0);
            else       run = 1'b0;
            if (v > 999999) s = 7'h3F;
            else if (run)   s = 7'h7F;
            else            s = tbl[d];
            if (!al) s = ~s;
            r[7*i +: 7] = s;
        end
        return r;
    endfunction

    task automatic tick;
        @(posedge clock);
        #1;
    endtask

    task automatic push(int v);
        exp_t e;
        e.v   = 20'(v);
        e.a   = model(v, 1'b1, 1'b1);
        e.nb  = model(v, 1'b0, 1'b1);
        e.inv = model(v, 1'b1, 1'b0);
        sb.push_back(e);
    endtask

    task automatic test_reset;
        reset_n = 1'b1;
        start   = 1'b0;
        bin     = '0;
        tick;
        tick;
        #3 reset_n = 1'b0;
        #1;
        n_tot++;
        if (busy_a !== 1'b0 || done_a !== 1'b0) begin
            $display("FAIL reset_ctl: busy=%b done=%b want 0 0", busy_a, done_a);
        end else n_pass++;
        n_tot++;
        if (hex_a !== {6{7'h7F}}) begin
            $display("FAIL reset_hex: got %h want %h", hex_a, {6{7'h7F}});
        end else n_pass++;
        n_tot++;
        if (busy_b !== 1'b0 || hex_b !== {6{7'h7F}}) begin
            $display("FAIL reset_nb: busy=%b hex=%h", busy_b, hex_b);
        end else n_pass++;
        tick;
        tick;
        reset_n = 1'b1;
        tick;
    endtask

    task automatic test_basic;
        int   n = 0;
        int   busy_n = 0;
        exp_t e;
        bin   = 20'd123456;
        start = 1'b1;
        tick;
        start = 1'b0;
        push(123456);
        while (!done_a && n < 40) begin
            if (busy_a) busy_n++;
            tick;
            n++;
        end
        n_tot++;
        if (done_a !== 1'b1) begin
            $display("FAIL basic_timeout: done=%b after %0d cycles", done_a, n);
        end else n_pass++;
        n_tot++;
        if (n != 21 || busy_n != 21) begin
            $display("FAIL basic_latency: done at %0d busy %0d want 21 21", n, busy_n);
        end else n_pass++;
        n_tot++;
        if (busy_a !== 1'b0) begin
            $display("FAIL basic_busy_done: busy=%b during done", busy_a);
        end else n_pass++;
        e = sb.pop_front();
        n_tot++;
        if (hex_a !== e.a) begin
            $display("FAIL basic_hex: got %h want %h", hex_a, e.a);
        end else n_pass++;
        n_tot++;
        if (hex_a !== {7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02}) begin
            $display("FAIL basic_literal: got %h", hex_a);
        end else n_pass++;
        tick;
        n_tot++;
        if (done_a !== 1'b0) begin
            $display("FAIL basic_pulse: done=%b want 0", done_a);
        end else n_pass++;
    endtask

    task automatic test_values;
        int   vals [7];
        int   n;
        exp_t e;
        vals = '{0, 1000, 999999, 1000000, 20'hFFFFF,
                 int'($urandom_range(0, 999999)),
                 int'($urandom_range(0, 999))};
        foreach (vals[k]) begin
            bin   = 20'(vals[k]);
            start = 1'b1;
            tick;
            start = 1'b0;
            push(vals[k]);
            n = 0;
            while (!done_a && n < 40) begin
                tick;
                n++;
            end
            e = sb.pop_front();
            n_tot++;
            if (done_a !== 1'b1 || done_b !== 1'b1 || done_c !== 1'b1) begin
                $display("FAIL val_done[%0d]: done=%b%b%b", vals[k], done_a, done_b, done_c);
            end else n_pass++;
            n_tot++;
            if (hex_a !== e.a) begin
                $display("FAIL val_hex[%0d]: got %h want %h", vals[k], hex_a, e.a);
            end else n_pass++;
            n_tot++;
            if (hex_b !== e.nb) begin
                $display("FAIL val_noblank[%0d]: got %h want %h", vals[k], hex_b, e.nb);
            end else n_pass++;
            n_tot++;
            if (hex_c !== e.inv) begin
                $display("FAIL val_inv[%0d]: got %h want %h", vals[k], hex_c, e.inv);
            end else n_pass++;
            tick;
        end
    endtask

    task automatic test_ignore_start;
        int   n = 0;
        exp_t e;
        bin   = 20'd111111;
        start = 1'b1;
        tick;
        start = 1'b0;
        push(111111);
        while (!done_a && n < 40) begin
            if (n == 4) begin
                start = 1'b1;
                bin   = 20'd222222;
            end
            if (n == 5) start = 1'b0;
            if (n == 19) begin
                start = 1'b1;
                bin   = 20'd333333;
            end
            tick;
            n++;
        end
        start = 1'b0;
        e = sb.pop_front();
        n_tot++;
        if (done_a !== 1'b1 || hex_a !== e.a) begin
            $display("FAIL ignore_hex: done=%b got %h want %h", done_a, hex_a, e.a);
        end else n_pass++;
        tick;
        n_tot++;
        if (busy_a !== 1'b0 || done_a !== 1'b0) begin
            $display("FAIL ignore_queue: busy=%b done=%b want 0 0", busy_a, done_a);
        end else n_pass++;
    endtask

    task automatic test_back_to_back;
        int   t = 0;
        int   last = 0;
        int   g;
        exp_t e;
        bin   = 20'd314159;
        start = 1'b1;
        for (int p = 0; p < 3; p++) push(314159);
        tick;
        for (int p = 0; p < 3; p++) begin
            g = 0;
            while (!done_a && g < 60) begin
                tick;
                t++;
                g++;
            end
            if (p == 2) start = 1'b0;
            e = sb.pop_front();
            n_tot++;
            if (done_a !== 1'b1 || hex_a !== e.a) begin
                $display("FAIL b2b_hex[%0d]: done=%b got %h want %h", p, done_a, hex_a, e.a);
            end else n_pass++;
            n_tot++;
            if ((p == 0 && t != 21) || (p > 0 && t - last != 22)) begin
                $display("FAIL b2b_spacing[%0d]: at %0d prev %0d", p, t, last);
            end else n_pass++;
            last = t;
            tick;
            t++;
        end
        n_tot++;
        if (busy_a !== 1'b0) begin
            $display("FAIL b2b_stop: busy=%b want 0", busy_a);
        end else n_pass++;
    endtask

    task automatic test_reset_abort;
        int   n = 0;
        int   pulses = 0;
        exp_t e;
        bin   = 20'd654321;
        start = 1'b1;
        tick;
        start = 1'b0;
        repeat (10) tick;
        #2 reset_n = 1'b0;
        #1;
        n_tot++;
        if (busy_a !== 1'b0 || done_a !== 1'b0 || hex_a !== {6{7'h7F}}) begin
            $display("FAIL abort_reset: busy=%b done=%b hex=%h", busy_a, done_a, hex_a);
        end else n_pass++;
        n_tot++;
        if (hex_c !== 42'h0) begin
            $display("FAIL abort_inv: got %h want 0", hex_c);
        end else n_pass++;
        #1 reset_n = 1'b1;
        repeat (30) begin
            tick;
            if (done_a) pulses++;
        end
        n_tot++;
        if (pulses != 0 || hex_a !== {6{7'h7F}}) begin
            $display("FAIL abort_nodone: pulses=%0d hex=%h", pulses, hex_a);
        end else n_pass++;
        bin   = 20'd42;
        start = 1'b1;
        tick;
        start = 1'b0;
        push(42);
        while (!done_a && n < 40) begin
            tick;
            n++;
        end
        e = sb.pop_front();
        n_tot++;
        if (done_a !== 1'b1 || hex_a !== e.a) begin
            $display("FAIL abort_restart: done=%b got %h want %h", done_a, hex_a, e.a);
        end else n_pass++;
        n_tot++;
        if (hex_a !== {7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h19, 7'h24}) begin
            $display("FAIL abort_literal: got %h", hex_a);
        end else n_pass++;
        tick;
    endtask

    initial begin
        test_reset;
        test_basic;
        test_values;
        test_ignore_start;
        test_back_to_back;
        test_reset_abort;
        n_tot++;
        if (sb.size() != 0) begin
            $display("FAIL scoreboard_left: %0d entries want 0", sb.size());
        end else n_pass++;
        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

endmodule
